// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Optional lock override is enabled with ARB_LOCK_EN.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_MAX_N = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  // Reference circular pick over up to ARB_MAX_N requesters.
  function automatic pick_t rr_pick_f(
    input logic [ARB_MAX_N-1:0] req,
    input int unsigned          start,
    input int unsigned          n
  );
    pick_t       p;
    int unsigned s;
    p = '0;
    for (int unsigned k = 0; k < n; k++) begin
      s = start + k;
      if (s >= n) s = s - n;
      if (!p.found && req[s]) begin
        p.found = 1'b1;
        p.idx   = s[4:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority pick: rotate by start, find lowest set bit,
// then map the result back to the original requester index.
module rr_pick #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] enc;
  logic [IDX_W:0]   sum;
  int               j;

  always_comb begin
    rot = '0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = i + int'(start);
      if (j >= N) j = j - N;
      rot[i] = req[j];
    end
  end

  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
  end

  always_comb begin
    sum = {1'b0, enc} + {1'b0, start};
    if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
    idx   = sum[IDX_W-1:0];
    found = |req;
  end

endmodule

// File: rtl/arbiter_rr_hold.sv
// Round-robin arbiter with registered one-hot grant and bounded hold.
// Define ARB_LOCK_EN to add a lock input that extends a tenure.
module arbiter_rr_hold
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  localparam int IDX_W   = $clog2(N),
  localparam int HOLD_W  = $clog2(MAX_HOLD + 1)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ARB_LOCK_EN
  input  logic              lock,
`endif
  input  logic [N-1:0]      req,
  output logic [N-1:0]      grant,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [HOLD_W-1:0] HMAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST = IDX_W'(N - 1);

  arb_state_e        state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  last_q, last_d;

  logic              ovr;
  logic              keep;
  logic [IDX_W-1:0]  start;
  logic              pk_found;
  logic [IDX_W-1:0]  pk_idx;

`ifdef ARB_LOCK_EN
  assign ovr = lock;
`else
  assign ovr = 1'b0;
`endif

  // In GRANT last_q equals the owner, so one start serves both states
  // and the owner naturally lands at the end of the scan.
  assign start = (last_q == LAST) ? '0 : last_q + 1'b1;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .start (start),
    .found (pk_found),
    .idx   (pk_idx)
  );

  assign keep = (state_q == GRANT) && req[idx_q] &&
                ((hold_q < HMAX) || ovr);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    last_d  = last_q;
    if (keep) begin
      if (hold_q != HMAX) hold_d = hold_q + 1'b1;
    end else if (pk_found) begin
      state_d         = GRANT;
      grant_d         = '0;
      grant_d[pk_idx] = 1'b1;
      idx_d           = pk_idx;
      hold_d          = HOLD_W'(1);
      last_d          = pk_idx;
    end else begin
      state_d = IDLE;
      grant_d = '0;
      idx_d   = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      last_q  <= LAST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = idx_q;
  assign hold_cnt    = hold_q;

endmodule
